pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Issue-control and hazard unit for the 16-bit, 8-bit-PC in-order pipeline. It sits between the instruction fetch stage and decode. It tracks the destination registers of in-flight instructions in a scoreboard and holds the PC and IF/ID register on read-after-write hazards. It also flushes the decode slot on a taken branch and drains the pipeline to a halted state on a HALT instruction.

## Interface
Parameters:
- DEPTH, 3, number of pipeline slots after decode tracked by the scoreboard (EX, MEM, WB); legal 1–6.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_instr  in  16  instruction in decode: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2.
- id_valid  in  1  id_instr is a real instruction, not a bubble.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- pc_hold  out  1  fetch must keep PC and not advance.
- ifid_hold  out  1  IF/ID register keeps its contents.
- ifid_flush  out  1  IF/ID register loads 16'b0 next edge.
- issue_valid  out  1  decode instruction advances to EX this cycle.
- halted  out  1  pipeline drained after HALT.
- stall_cycles  out  16  saturating count of hazard-stall cycles.

## Operation
- Opcode classes:
  - 0000 NOP: no reads, no write.
  - 0001–1011: write rd, read rs1 and rs2.
  - 1100–1110: no write, read rs1 and rs2 (1100 = branch).
  - 1111 HALT: no reads, no write.
- Scoreboard: DEPTH entries of {valid, rd}. Each posedge shifts slot k to slot k+1; slot DEPTH-1 is discarded. Slot 0 loads {1, rd} if issue_valid and the instruction is write-class, else {0, x}.
- hazard = id_valid and the opcode is read-class and some valid slot's rd equals rs1 or rs2. r0 is not special.
- FSM states are RUN, DRAIN and HALTED.
- RUN behaviour, in priority order:
  1. ex_branch_taken=1: ifid_flush=1, issue_valid=0, pc_hold=0, ifid_hold=0. No stall is counted.
  2. hazard=1: pc_hold=1, ifid_hold=1, issue_valid=0, and stall_cycles increments. A bubble enters slot 0.
  3. Otherwise: issue_valid=id_valid and all holds are 0. If the issued opcode is 1111, the next state is DRAIN.
- DRAIN: pc_hold=1, ifid_hold=1, issue_valid=0. ex_branch_taken is ignored. The next state is HALTED once all scoreboard slots are invalid.
- HALTED: pc_hold=1, ifid_hold=1, issue_valid=0, halted=1. It stays here until rst.
- stall_cycles saturates at 16'hFFFF.

## Timing
- pc_hold, ifid_hold, ifid_flush and issue_valid are combinational from the current state, scoreboard, id_instr, id_valid and ex_branch_taken. They take effect at the same posedge.
- The scoreboard, FSM state, halted and stall_cycles are registered.
- There is no forwarding. A consumer immediately after its producer stalls exactly DEPTH cycles. A consumer with one unrelated instruction in between stalls DEPTH-1 cycles.
- Reset, including mid-stall or mid-drain, takes effect on the rst edge:
  - all slots invalid, state RUN, halted=0, stall_cycles=0.
  - outputs in the reset cycle: pc_hold=0, ifid_hold=0, ifid_flush=0, issue_valid=0.
- A branch and a hazard in the same cycle resolve as a flush. The hazarding instruction is discarded, not stalled.
- A HALT issues even if the scoreboard is non-empty. DRAIN lasts until the youngest entry leaves slot DEPTH-1.

## Test plan
- Dependent pair: issue 0001_011_001_010_000 (writes r3), then 0010_001_011_000_000 (reads r3). Required: pc_hold=1 for exactly 3 cycles, the consumer issues in the 4th cycle, and stall_cycles=3.
- Independent stream: 8 ALU instructions with disjoint registers. Required: issue_valid=1 every cycle, pc_hold never asserted, stall_cycles=0.
- Branch during hazard: hold a stall on r3 and pulse ex_branch_taken in the 2nd stall cycle. Required: ifid_flush=1 that cycle, issue_valid=0, and no further stall for the flushed instruction.
- HALT with in-flight writer: issue a writer of r5, then 1111_000_000_000_000. Required: DRAIN for 3 cycles, then halted=1 with pc_hold=1. halted stays 1 under further ex_branch_taken pulses.
- Reset mid-drain: assert rst during DRAIN. Required: next cycle halted=0, all slots empty, and a dependent of the pre-reset writer issues without stall.
- Saturation: force 70000 stall cycles. Required: stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Issue-control and hazard unit between fetch and decode of the 16-bit,
// 8-bit-PC in-order pipeline. A scoreboard shift register remembers the
// destination register of every instruction in the DEPTH slots after decode
// (EX, MEM, WB, ...). Without forwarding, any decode read of a register still
// in the scoreboard holds fetch and IF/ID until the producer retires. A taken
// branch in EX flushes the decode slot. A HALT drains the pipeline into a
// terminal halted state that only rst leaves.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   id_instr[15:0]   decode instruction: [15:12] opcode, [11:9] rd,
//                    [8:6] rs1, [5:3] rs2
//   id_valid         id_instr is a real instruction (not a bubble)
//   ex_branch_taken  branch in EX resolved taken this cycle
//   pc_hold          fetch keeps the PC
//   ifid_hold        IF/ID register keeps its contents
//   ifid_flush       IF/ID register loads 16'b0 at the next edge
//   issue_valid      decode instruction advances to EX this cycle
//   halted           pipeline drained after HALT
//   stall_cycles     saturating count of hazard-stall cycles
module pipeline_hazard_controller #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_branch_taken,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        issue_valid,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0] state;
  logic [1:0] state_next;
  logic       count_stall;

  logic [DEPTH-1:0] sb_vld;
  logic [2:0]       sb_rd [DEPTH];

  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       read_cls;
  logic       write_cls;
  logic       match;
  logic       hazard;
  logic       sb_empty;
  logic       unused_bits;

  assign opcode      = id_instr[15:12];
  assign rd          = id_instr[11:9];
  assign rs1         = id_instr[8:6];
  assign rs2         = id_instr[5:3];
  assign unused_bits = ^id_instr[2:0];

  // NOP (0000) and HALT (1111) neither read nor write; 1100-1110 only read.
  assign read_cls  = (opcode != 4'h0) && (opcode != 4'hF);
  assign write_cls = (opcode != 4'h0) && (opcode <= 4'hB);

  always_comb begin
    match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_vld[k] && ((sb_rd[k] == rs1) || (sb_rd[k] == rs2))) begin
        match = 1'b1;
      end
    end
  end

  assign hazard   = id_valid && read_cls && match;
  assign sb_empty = ~|sb_vld;
  assign halted   = (state == ST_HALTED);

  // Control outputs are forced low during the reset cycle so nothing upstream
  // acts on a half-initialised scoreboard.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    issue_valid = 1'b0;
    count_stall = 1'b0;
    state_next  = state;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          // A taken branch wins over a hazard: the hazarding instruction is
          // on the wrong path, so it is discarded rather than stalled.
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
          end else if (hazard) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            count_stall = 1'b1;
          end else begin
            issue_valid = id_valid;
            if (id_valid && (opcode == 4'hF)) begin
              state_next = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          if (sb_empty) begin
            state_next = ST_HALTED;
          end
        end
        ST_HALTED: begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // Control registers: FSM, stall counter and scoreboard valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      stall_cycles <= 16'd0;
      sb_vld       <= '0;
    end else begin
      state <= state_next;
      if (count_stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      sb_vld[0] <= issue_valid && write_cls;
      for (int k = 1; k < DEPTH; k++) begin
        sb_vld[k] <= sb_vld[k-1];
      end
    end
  end

  // Scoreboard destination registers: data only, qualified by sb_vld.
  always_ff @(posedge clk) begin
    sb_rd[0] <= rd;
    for (int k = 1; k < DEPTH; k++) begin
      sb_rd[k] <= sb_rd[k-1];
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        br;
  logic        pc_hold, ifid_hold, ifid_flush, issue_valid, halted;
  logic [15:0] stall_cycles;
  logic [3:0]  ctl;

  logic        s_rst;
  logic [15:0] s_instr;
  logic        s_valid, s_br;
  logic        s_pc_hold, s_ifid_hold, s_ifid_flush, s_issue_valid, s_halted;
  logic [15:0] s_stall;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [15:0] P_R3   = 16'h1650; // 0001_011_001_010_000 writes r3
  localparam logic [15:0] C_R3   = 16'h22C0; // 0010_001_011_000_000 reads r3
  localparam logic [15:0] U_R7   = 16'h1E00; // 0001_111_000_000_000 writes r7
  localparam logic [15:0] W_R5   = 16'h1A00; // 0001_101_000_000_000 writes r5
  localparam logic [15:0] R_R5   = 16'h2340; // 0010_001_101_000_000 reads r5
  localparam logic [15:0] HALT   = 16'hF000;
  localparam logic [15:0] SELF3  = 16'h16C0; // 0001_011_011_000_000 r3 <- r3

  always #5 clk = ~clk;

  assign ctl = {pc_hold, ifid_hold, ifid_flush, issue_valid};

  pipeline_hazard_controller #(.DEPTH(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_instr        (id_instr),
    .id_valid        (id_valid),
    .ex_branch_taken (br),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .issue_valid     (issue_valid),
    .halted          (halted),
    .stall_cycles    (stall_cycles)
  );

  pipeline_hazard_controller #(.DEPTH(6)) u_sat (
    .clk             (clk),
    .rst             (s_rst),
    .id_instr        (s_instr),
    .id_valid        (s_valid),
    .ex_branch_taken (s_br),
    .pc_hold         (s_pc_hold),
    .ifid_hold       (s_ifid_hold),
    .ifid_flush      (s_ifid_flush),
    .issue_valid     (s_issue_valid),
    .halted          (s_halted),
    .stall_cycles    (s_stall)
  );

  // Apply one cycle of inputs away from the active edge; outputs settle by #1.
  task automatic drive(input logic r, input logic [15:0] ins, input logic v,
                       input logic b);
    @(negedge clk);
    rst      = r;
    id_instr = ins;
    id_valid = v;
    br       = b;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, P_R3, 1'b1, 1'b1);
    tests_run++;
    if (ctl !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, 4'b0000);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tests_run++;
    if (stall_cycles !== 16'd0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: got stall=%0d halted=%b expected stall=0 halted=0",
               stall_cycles, halted);
    end
    tests_run++;
    if (ctl !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_idle_ctl: got %b expected %b", ctl, 4'b0000);
    end
  endtask

  task automatic test_independent();
    logic [15:0] ins;
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ins = {4'(i % 11 + 1), 3'(i % 7 + 1), 9'b0};
      drive(1'b0, ins, 1'b1, 1'b0);
      tests_run++;
      if (ctl !== 4'b0001) begin
        tests_failed++;
        $display("FAIL indep_issue[%0d]: got ctl=%b expected %b", i, ctl, 4'b0001);
      end
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tests_run++;
    if (stall_cycles !== 16'd0) begin
      tests_failed++;
      $display("FAIL indep_stalls: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_dependent_pair();
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, P_R3, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b0001) begin
      tests_failed++;
      $display("FAIL dep_producer: got ctl=%b expected %b", ctl, 4'b0001);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, C_R3, 1'b1, 1'b0);
      if (issue_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      n++;
      tests_run++;
      if (ctl !== 4'b1100) begin
        tests_failed++;
        $display("FAIL dep_stall_ctl[%0d]: got %b expected %b", k, ctl, 4'b1100);
      end
    end
    tests_run++;
    if (got !== 1'b1 || n != 3) begin
      tests_failed++;
      $display("FAIL dep_stall_len: got issued=%b stalls=%0d expected issued=1 stalls=3",
               got, n);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tests_run++;
    if (stall_cycles !== 16'd3) begin
      tests_failed++;
      $display("FAIL dep_stall_count: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_gap();
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, P_R3, 1'b1, 1'b0);
    drive(1'b0, U_R7, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b0001) begin
      tests_failed++;
      $display("FAIL gap_unrelated: got ctl=%b expected %b", ctl, 4'b0001);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, C_R3, 1'b1, 1'b0);
      if (issue_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    tests_run++;
    if (got !== 1'b1 || n != 2) begin
      tests_failed++;
      $display("FAIL gap_stall_len: got issued=%b stalls=%0d expected issued=1 stalls=2",
               got, n);
    end
  endtask

  task automatic test_branch_during_hazard();
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, P_R3, 1'b1, 1'b0);
    drive(1'b0, C_R3, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b1100) begin
      tests_failed++;
      $display("FAIL br_first_stall: got ctl=%b expected %b", ctl, 4'b1100);
    end
    drive(1'b0, C_R3, 1'b1, 1'b1);
    tests_run++;
    if (ctl !== 4'b0010) begin
      tests_failed++;
      $display("FAIL br_flush: got ctl=%b expected %b", ctl, 4'b0010);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b0001) begin
      tests_failed++;
      $display("FAIL br_after_flush: got ctl=%b expected %b", ctl, 4'b0001);
    end
    tests_run++;
    if (stall_cycles !== 16'd1) begin
      tests_failed++;
      $display("FAIL br_stall_count: got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_halt();
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, W_R5, 1'b1, 1'b0);
    drive(1'b0, HALT, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b0001) begin
      tests_failed++;
      $display("FAIL halt_issue: got ctl=%b expected %b", ctl, 4'b0001);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, R_R5, 1'b1, k == 1);
      if (halted === 1'b1) begin
        got = 1'b1;
        break;
      end
      n++;
      tests_run++;
      if (ctl !== 4'b1100) begin
        tests_failed++;
        $display("FAIL halt_drain_ctl[%0d]: got %b expected %b", k, ctl, 4'b1100);
      end
    end
    tests_run++;
    if (got !== 1'b1 || n != 3) begin
      tests_failed++;
      $display("FAIL halt_drain_len: got halted=%b drain=%0d expected halted=1 drain=3",
               got, n);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, R_R5, 1'b1, 1'b1);
      tests_run++;
      if (halted !== 1'b1 || ctl !== 4'b1100) begin
        tests_failed++;
        $display("FAIL halt_sticky[%0d]: got halted=%b ctl=%b expected halted=1 ctl=1100",
                 k, halted, ctl);
      end
    end
    tests_run++;
    if (stall_cycles !== 16'd0) begin
      tests_failed++;
      $display("FAIL halt_stall_count: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, W_R5, 1'b1, 1'b0);
    drive(1'b0, HALT, 1'b1, 1'b0);
    drive(1'b0, R_R5, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rdrain_in_drain: got ctl=%b expected %b", ctl, 4'b1100);
    end
    drive(1'b1, R_R5, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rdrain_reset_ctl: got %b expected %b", ctl, 4'b0000);
    end
    drive(1'b0, R_R5, 1'b1, 1'b0);
    tests_run++;
    if (ctl !== 4'b0001 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdrain_dep_issue: got ctl=%b halted=%b expected ctl=0001 halted=0",
               ctl, halted);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tests_run++;
    if (stall_cycles !== 16'd0) begin
      tests_failed++;
      $display("FAIL rdrain_stall_count: got %0d expected 0", stall_cycles);
    end
  endtask

  // DEPTH=6 instance with a self-dependent instruction: one issue then six
  // stalls, repeating, so after n cycles the count is n - ceil(n/7).
  task automatic test_saturation();
    @(negedge clk);
    s_rst   = 1'b1;
    s_instr = SELF3;
    s_valid = 1'b1;
    s_br    = 1'b0;
    @(negedge clk);
    s_rst = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (s_stall !== 16'd56172) begin
      tests_failed++;
      $display("FAIL sat_midpoint: got %0d expected 56172", s_stall);
    end
    repeat (16135) @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (s_stall !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_limit: got %h expected ffff", s_stall);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (s_stall !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_hold: got %h expected ffff", s_stall);
    end
  endtask

  initial begin
    rst      = 1'b1;
    id_instr = 16'h0000;
    id_valid = 1'b0;
    br       = 1'b0;
    s_rst    = 1'b1;
    s_instr  = 16'h0000;
    s_valid  = 1'b0;
    s_br     = 1'b0;
    test_reset();
    test_independent();
    test_dependent_pair();
    test_gap();
    test_branch_during_hazard();
    test_halt();
    test_reset_mid_drain();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
